// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// The master drives address and strobes; the slave returns registered readdata.
interface avalon_multi_timer_if;
  logic [5:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_multi_timer.sv
// NUM_CH independent prescaled down-counters with PWM compare and snapshot,
// exposed as a 32-bit Avalon-MM slave with read latency 1 and one combined irq.
module avalon_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_multi_timer_if.slave  bus,
  output logic                 irq,
  output logic [NUM_CH-1:0]    pwm_out
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  logic             wr;
  logic [2:0]       ch;
  logic [2:0]       rg;
  logic [CNT_W-1:0] wdata_cnt;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign ch           = bus.address[5:3];
  assign rg           = bus.address[2:0];
  assign wdata_cnt    = bus.writedata[CNT_W-1:0];
  assign unused_wdata = ^bus.writedata;

  logic [CNT_W-1:0] counter  [NUM_CH];
  logic [CNT_W-1:0] period   [NUM_CH];
  logic [CNT_W-1:0] compare  [NUM_CH];
  logic [CNT_W-1:0] snap     [NUM_CH];
  logic [7:0]       pre      [NUM_CH];
  logic [7:0]       prescale [NUM_CH];
  logic [NUM_CH-1:0] ito, cont, run, to;

  logic [NUM_CH-1:0] status_wr, ctrl_wr, period_wr, compare_wr, snap_wr;
  logic [NUM_CH-1:0] start, stop, tick, timeout;

  // Channels outside NUM_CH never match the decode, so their writes vanish.
  always_comb begin
    status_wr  = '0;
    ctrl_wr    = '0;
    period_wr  = '0;
    compare_wr = '0;
    snap_wr    = '0;
    start      = '0;
    stop       = '0;
    tick       = '0;
    timeout    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && (ch == 3'(i))) begin
        status_wr[i]  = (rg == 3'd0);
        ctrl_wr[i]    = (rg == 3'd1);
        period_wr[i]  = (rg == 3'd2);
        compare_wr[i] = (rg == 3'd3);
        snap_wr[i]    = (rg == 3'd4);
      end
      start[i]   = ctrl_wr[i] & bus.writedata[2];
      stop[i]    = ctrl_wr[i] & bus.writedata[3];
      tick[i]    = run[i] && (prescale[i] == pre[i]);
      timeout[i] = tick[i] && (counter[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        counter[i]  <= RST_CNT;
        period[i]   <= RST_CNT;
        compare[i]  <= '0;
        snap[i]     <= '0;
        pre[i]      <= '0;
        prescale[i] <= '0;
      end
      ito     <= '0;
      cont    <= '0;
      run     <= '0;
      to      <= '0;
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ctrl_wr[i]) begin
          ito[i]  <= bus.writedata[0];
          cont[i] <= bus.writedata[1];
          pre[i]  <= bus.writedata[15:8];
        end
        if (compare_wr[i]) compare[i] <= wdata_cnt;
        if (snap_wr[i])    snap[i]    <= counter[i];
        if (period_wr[i])  period[i]  <= wdata_cnt;

        // A PERIOD write reloads the counter and overrides any tick on that edge.
        if (period_wr[i]) begin
          counter[i]  <= wdata_cnt;
          prescale[i] <= '0;
        end else if (tick[i]) begin
          prescale[i] <= '0;
          counter[i]  <= timeout[i] ? period[i] : counter[i] - CNT_W'(1);
        end else if (run[i]) begin
          prescale[i] <= prescale[i] + 8'd1;
        end else begin
          prescale[i] <= '0;
        end

        if (start[i])
          run[i] <= 1'b1;
        else if (stop[i] || period_wr[i] || (timeout[i] && !cont[i]))
          run[i] <= 1'b0;

        if (status_wr[i])
          to[i] <= 1'b0;
        else if (timeout[i])
          to[i] <= 1'b1;

        pwm_out[i] <= run[i] && (counter[i] < compare[i]);
      end
    end
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 3'(i)) begin
        case (rg)
          3'd0:    rd_mux = {30'b0, run[i], to[i]};
          3'd1:    rd_mux = {16'b0, pre[i], 6'b0, cont[i], ito[i]};
          3'd2:    rd_mux[CNT_W-1:0] = period[i];
          3'd3:    rd_mux[CNT_W-1:0] = compare[i];
          3'd4:    rd_mux[CNT_W-1:0] = snap[i];
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.readdata <= '0;
    else
      bus.readdata <= rd_mux;
  end

  assign irq = |(to & ito);

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer: reads are scored through an expectation
// queue drained by a monitor; irq and pwm_out are compared directly each cycle.
module tb_avalon_multi_timer;

  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              irq;
  logic [NUM_CH-1:0] pwm_out;

  avalon_multi_timer_if bus ();

  avalon_multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (32),
    .RESET_PERIOD (49999)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q  [$];
  string       name_q [$];
  bit          rd_flag = 1'b0;

  // Bench-side record of which edges sampled a read request.
  always @(posedge clk) rd_flag <= bus.chipselect && bus.write_n;

  always @(negedge clk) begin
    if (rd_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_read: got 0x%08h, no expectation queued", bus.readdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (bus.readdata !== e) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", n, bus.readdata, e);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [31:0] exp, input string name);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    bus.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    idle(3);
    check_output("irq_reset", {31'b0, irq}, 32'd0);
    check_output("pwm_reset", 32'(pwm_out), 32'd0);
    check_output("readdata_reset", bus.readdata, 32'd0);
    reset = 1'b0;

    // Reset register values.
    bus_read(6'd0, 32'd0,     "ch0_status_rst");
    bus_read(6'd1, 32'd0,     "ch0_control_rst");
    bus_read(6'd2, 32'd49999, "ch0_period_rst");
    bus_read(6'd3, 32'd0,     "ch0_compare_rst");
    bus_read(6'd4, 32'd0,     "ch0_snap_rst");
    bus_read(6'd5, 32'd0,     "ch0_reg5_rst");
    bus_read(6'd10, 32'd49999, "ch1_period_rst");

    // Channel 1 continuous, PERIOD 4, PRE 0: timeouts 5 edges after START, then every 5.
    bus_write(6'd10, 32'd4);
    bus_write(6'd9, 32'h7);
    idle(4);
    check_output("ch1_irq_before_to", {31'b0, irq}, 32'd0);
    idle(1);
    check_output("ch1_irq_first_to", {31'b0, irq}, 32'd1);
    bus_write(6'd8, 32'd0);
    check_output("ch1_irq_cleared", {31'b0, irq}, 32'd0);
    idle(3);
    check_output("ch1_irq_before_2nd", {31'b0, irq}, 32'd0);
    idle(1);
    check_output("ch1_irq_second_to", {31'b0, irq}, 32'd1);
    bus_read(6'd8, 32'd3, "ch1_status_run_to");
    bus_write(6'd8, 32'd0);
    idle(2);
    bus_write(6'd8, 32'd0);
    check_output("ch1_irq_clear_beats_set", {31'b0, irq}, 32'd0);
    bus_read(6'd8, 32'd2, "ch1_status_clear_wins");
    bus_write(6'd9, 32'h8);
    bus_read(6'd8, 32'd0, "ch1_status_stopped");
    bus_write(6'd9, 32'hC);
    bus_read(6'd8, 32'd2, "ch1_start_beats_stop");
    bus_write(6'd9, 32'h8);

    // Restart from counter 0: immediate reload, then snapshot mid-count.
    bus_write(6'd9, 32'h6);
    idle(2);
    bus_write(6'd12, 32'd0);
    bus_write(6'd9, 32'h8);
    bus_read(6'd12, 32'd3, "ch1_snap_pre_decrement");

    // Channel 0 one-shot, PERIOD 3, PRE 2: timeout 12 edges after START.
    bus_write(6'd2, 32'd3);
    bus_write(6'd1, 32'h205);
    idle(11);
    check_output("ch0_irq_before_oneshot", {31'b0, irq}, 32'd0);
    idle(1);
    check_output("ch0_irq_oneshot", {31'b0, irq}, 32'd1);
    bus_read(6'd1, 32'h201, "ch0_control_readback");
    bus_read(6'd0, 32'd1,   "ch0_status_oneshot_stopped");
    bus_write(6'd4, 32'd0);
    bus_read(6'd4, 32'd3,   "ch0_counter_reloaded");
    bus_read(6'd2, 32'd3,   "ch0_period_readback");
    bus_write(6'd0, 32'd0);
    check_output("ch0_irq_cleared", {31'b0, irq}, 32'd0);

    // PWM: PERIOD 9, COMPARE 3, continuous -> high on 3 of every 10 cycles.
    bus_write(6'd2, 32'd9);
    bus_write(6'd3, 32'd3);
    bus_write(6'd1, 32'h6);
    for (int k = 4; k <= 23; k++) begin
      idle(1);
      check_output($sformatf("pwm_cycle%0d", k), 32'(pwm_out),
                   ((k % 10) >= 1 && (k % 10) <= 3) ? 32'd1 : 32'd0);
    end
    bus_write(6'd3, 32'd0);
    for (int k = 25; k <= 36; k++) begin
      idle(1);
      check_output($sformatf("pwm_cmp0_cycle%0d", k), 32'(pwm_out), 32'd0);
    end

    // PERIOD write while running stops the channel and loads the counter.
    bus_write(6'd2, 32'd100);
    bus_write(6'd0, 32'd0);
    bus_write(6'd4, 32'd0);
    bus_read(6'd4, 32'd100, "ch0_snap_after_period_wr");
    bus_read(6'd0, 32'd0,   "ch0_status_after_period_wr");

    // Nonexistent channel 7 is inert.
    bus_write(6'd58, 32'd5);
    bus_write(6'd57, 32'h7);
    bus_write(6'd60, 32'd0);
    bus_read(6'd58, 32'd0,   "ch7_period");
    bus_read(6'd57, 32'd0,   "ch7_control");
    bus_read(6'd56, 32'd0,   "ch7_status");
    bus_read(6'd60, 32'd0,   "ch7_snap");
    bus_read(6'd2,  32'd100, "ch0_period_untouched");
    bus_read(6'd0,  32'd0,   "ch0_status_untouched");
    bus_read(6'd10, 32'd4,   "ch1_period_untouched");
    bus_read(6'd6,  32'd0,   "ch0_reg6");
    idle(2);
    check_output("irq_final", {31'b0, irq}, 32'd0);
    check_output("pwm_final", 32'(pwm_out), 32'd0);
    check_output("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
